// File: rtl/ssub_result_stage_pkg.sv
// ----------------------------------------------------------------------------
// ssub_result_stage_pkg
//   Shared definitions for the signed-subtractor result stage:
//     WIDTH_DEF        default datapath width
//     SAT_MAX/SAT_MIN  saturation limits at the default width
//     buf_state_e      occupancy of the output register + skid buffer
//     ovf_sub()        signed-overflow detect for a - b
// ----------------------------------------------------------------------------
package ssub_result_stage_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [WIDTH_DEF-1:0] SAT_MAX = {1'b0, {(WIDTH_DEF-1){1'b1}}};
    localparam logic [WIDTH_DEF-1:0] SAT_MIN = {1'b1, {(WIDTH_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,   // nothing held, out_valid low
        BUF_ONE   = 2'd1,   // output register full
        BUF_TWO   = 2'd2    // output register and skid entry full
    } buf_state_e;

    // a - b overflows only when the operands differ in sign and the result
    // sign differs from a. A pass-through result never overflows.
    function automatic logic ovf_sub(input logic sel, input logic a_msb,
                                     input logic b_msb, input logic r_msb);
        return ~sel & (a_msb ^ b_msb) & (r_msb ^ a_msb);
    endfunction

endpackage

// File: rtl/ssub_result_stage_if.sv
// ----------------------------------------------------------------------------
// ssub_result_stage_if
//   Input (valid/ready + mux result and operand sign bits) and output
//   (valid/ready + result and N/Z/V flags) channels of the result stage.
//   slave  : view of the result stage itself
//   master : view of the surrounding logic (upstream mux and writeback)
// ----------------------------------------------------------------------------
interface ssub_result_stage_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_sel;
    logic             in_a_msb;
    logic             in_b_msb;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_n;
    logic             out_z;
    logic             out_v;

    modport slave (
        input  in_valid, in_result, in_sel, in_a_msb, in_b_msb, out_ready,
        output in_ready, out_valid, out_result, out_n, out_z, out_v
    );

    modport master (
        output in_valid, in_result, in_sel, in_a_msb, in_b_msb, out_ready,
        input  in_ready, out_valid, out_result, out_n, out_z, out_v
    );
endinterface

// File: rtl/ssub_flag_calc.sv
// ----------------------------------------------------------------------------
// ssub_flag_calc
//   Combinational flag/saturation logic on the incoming mux result.
//   Ports:
//     result   in   WIDTH  selected mux output
//     sel      in   1      0 = difference, 1 = pass-through
//     a_msb    in   1      sign of minuend
//     b_msb    in   1      sign of subtrahend
//     res_out  out  WIDTH  result, clamped on overflow when SAT_EN=1
//     n, z     out  1      sign / zero of res_out
//     v        out  1      signed overflow of a - b (pre-saturation)
// ----------------------------------------------------------------------------
module ssub_flag_calc
    import ssub_result_stage_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [WIDTH-1:0] result,
    input  logic             sel,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic [WIDTH-1:0] res_out,
    output logic             n,
    output logic             z,
    output logic             v
);

    logic [WIDTH-1:0] sat_hi;
    logic [WIDTH-1:0] sat_lo;

    generate
        if (WIDTH == WIDTH_DEF) begin : g_def_limits
            assign sat_hi = SAT_MAX;
            assign sat_lo = SAT_MIN;
        end else begin : g_gen_limits
            assign sat_hi = {1'b0, {(WIDTH-1){1'b1}}};
            assign sat_lo = {1'b1, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_comb begin
        v       = ovf_sub(sel, a_msb, b_msb, result[WIDTH-1]);
        res_out = result;
        // Overflow direction follows the sign of a: negative a can only
        // underflow past the minimum, positive a only past the maximum.
        if (SAT_EN && v) begin
            res_out = a_msb ? sat_lo : sat_hi;
        end
        n = res_out[WIDTH-1];
        z = (res_out == '0);
    end

endmodule

// File: rtl/ssub_result_stage.sv
// ----------------------------------------------------------------------------
// ssub_result_stage
//   Registered output stage behind the subtractor's 2:1 result mux. Computes
//   N/Z/V (optionally saturating), then buffers finished entries in an output
//   register plus one skid entry so in_ready can come straight from a flop.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset      in   1      asynchronous active-high reset
//     bus        slave       input/output valid-ready channels
//     ovf_count  out  CNT_W  accepted overflow events, sticks at all-ones
//     ovf_clr    in   1      synchronous clear of ovf_count, beats increment
// ----------------------------------------------------------------------------
module ssub_result_stage
    import ssub_result_stage_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter bit SAT_EN = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    ssub_result_stage_if.slave   bus,
    output logic [CNT_W-1:0]     ovf_count,
    input  logic                 ovf_clr
);

    // Stored entry layout: {result, n, z, v}
    localparam int EW = WIDTH + 3;

    logic [WIDTH-1:0] f_result;
    logic             f_n;
    logic             f_z;
    logic             f_v;
    logic [EW-1:0]    in_entry;

    logic [EW-1:0]    out_q;
    logic [EW-1:0]    skid_q;

    buf_state_e       state_q;
    buf_state_e       state_d;
    logic             in_ready_q;

    logic             accept;
    logic             load_out;
    logic             load_skid;
    logic             out_from_skid;

    ssub_flag_calc #(
        .WIDTH  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_flag_calc (
        .result  (bus.in_result),
        .sel     (bus.in_sel),
        .a_msb   (bus.in_a_msb),
        .b_msb   (bus.in_b_msb),
        .res_out (f_result),
        .n       (f_n),
        .z       (f_z),
        .v       (f_v)
    );

    assign in_entry = {f_result, f_n, f_z, f_v};
    assign accept   = bus.in_valid & in_ready_q;

    // Next-state and datapath steering. The skid entry is only ever filled
    // from ONE while the output is stalled; in TWO in_ready is low so no
    // accept can happen there.
    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (accept) begin
                    state_d  = BUF_ONE;
                    load_out = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && bus.out_ready) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_d   = BUF_TWO;
                    load_skid = 1'b1;
                end else if (bus.out_ready) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: begin
                if (bus.out_ready) begin
                    state_d       = BUF_ONE;
                    out_from_skid = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    // in_ready is held low through reset and rises on the first edge after
    // release, since the next state is EMPTY then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_TWO);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= in_entry;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_entry;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_count <= '0;
        end else if (ovf_clr) begin
            ovf_count <= '0;
        end else if (accept && f_v && (ovf_count != {CNT_W{1'b1}})) begin
            ovf_count <= ovf_count + 1'b1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = (state_q != BUF_EMPTY);
    assign {bus.out_result, bus.out_n, bus.out_z, bus.out_v} = out_q;

endmodule
